fetch_unit: RTL and testbench

- Instruction-fetch stage: owns the fetch PC, issues requests to a variable-latency instruction memory, and presents InstrF/PCF/PCPlus4F/ValidF to the IF/ID pipeline register.
- Honours StallF from the hazard unit and PC redirects (PCSrcE/PCTargetE) from execute, discarding wrong-path responses.
- At most one memory request outstanding.

---
 rtl/fetch_imem_if.sv | 21 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_imem_if.sv
// Instruction-memory port: one request pulse out, one response (rvalid/rdata) back.
interface fetch_imem_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and keeps at most one memory request outstanding.
// Fills a single output slot for IF/ID and drops wrong-path responses after redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallF,
  input  logic                PCSrcE,
  input  logic [31:0]         PCTargetE,
  fetch_imem_if.master        imem,
  output logic [31:0]         InstrF,
  output logic [31:0]         PCF,
  output logic [31:0]         PCPlus4F,
  output logic                ValidF
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [XLEN-1:0]   instr_d, pcf_d, pcp4_d;
  logic              valid_d;
  logic              req_c;
  logic              unused_tgt_lo;

  // Redirect targets are word aligned; the low bits are ignored.
  assign unused_tgt_lo = ^PCTargetE[1:0];

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      InstrF   <= NOP_INSTR;
      PCF      <= RESET_PC;
      PCPlus4F <= RESET_PC + XLEN'(4);
      ValidF   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      InstrF   <= instr_d;
      PCF      <= pcf_d;
      PCPlus4F <= pcp4_d;
      ValidF   <= valid_d;
    end
  end

  // Next-state, slot update and request generation.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    instr_d  = InstrF;
    pcf_d    = PCF;
    pcp4_d   = PCPlus4F;
    valid_d  = ValidF;
    req_c    = reset && (state_q == IDLE) && !PCSrcE && (!ValidF || !StallF);

    if (PCSrcE) begin
      // Flush wins over stall; an in-flight response becomes wrong-path.
      pc_d    = {PCTargetE[XLEN-1:2], 2'b00};
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      case (state_q)
        WAIT:    state_d = imem.imem_rvalid ? IDLE : DROP;
        DROP:    state_d = imem.imem_rvalid ? IDLE : DROP;
        default: state_d = state_q;
      endcase
    end else begin
      if (ValidF && !StallF) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      if (req_c) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + XLEN'(4);
        state_d  = WAIT;
      end
      case (state_q)
        WAIT: begin
          if (imem.imem_rvalid) begin
            instr_d = imem.imem_rdata;
            pcf_d   = req_pc_q;
            pcp4_d  = req_pc_q + XLEN'(4);
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (imem.imem_rvalid) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked every cycle
// against a request/slot model with a variable-latency memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF;

  fetch_imem_if imem ();

  fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .StallF   (StallF),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .imem     (imem),
    .InstrF   (InstrF),
    .PCF      (PCF),
    .PCPlus4F (PCPlus4F),
    .ValidF   (ValidF)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: fetch pointer, one outstanding-request record, one output slot.
  logic [31:0] m_pc, m_paddr, m_instr, m_pcf;
  logic        m_pend, m_want, m_valid;
  // Memory: a single in-flight response with a countdown.
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_paddr = 32'h0; m_instr = NOP; m_pcf = 32'h0;
    m_pend = 1'b0; m_want = 1'b0; m_valid = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(input logic st, input logic rdr, input logic [31:0] tg, input logic spur);
    logic        exp_req, rv, resp;
    logic [31:0] rdat;
    @(negedge clk);
    StallF = st; PCSrcE = rdr; PCTargetE = tg;
    rv = 1'b0; rdat = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1; rdat = mem_addr ^ SALT; mem_busy = 1'b0;
      end
    end else if (spur) begin
      rv = 1'b1;
    end
    imem.imem_rvalid = rv; imem.imem_rdata = rdat;
    #1;
    exp_req = !m_pend && !rdr && (!m_valid || !st);
    chk("imem_req",  {31'b0, imem.imem_req}, {31'b0, exp_req});
    chk("imem_addr", imem.imem_addr, m_pc);
    chk("ValidF",    {31'b0, ValidF}, {31'b0, m_valid});
    chk("InstrF",    InstrF, m_instr);
    chk("PCF",       PCF, m_pcf);
    chk("PCPlus4F",  PCPlus4F, m_pcf + 32'd4);
    @(posedge clk);
    resp = rv && m_pend;
    if (rdr) begin
      m_valid = 1'b0; m_instr = NOP; m_pc = tg & 32'hFFFF_FFFC;
      if (resp) m_pend = 1'b0; else m_want = 1'b0;
    end else begin
      if (m_valid && !st) begin m_valid = 1'b0; m_instr = NOP; end
      if (resp) begin
        if (m_want) begin m_valid = 1'b1; m_instr = rdat; m_pcf = m_paddr; end
        m_pend = 1'b0;
      end
      if (exp_req) begin
        m_pend = 1'b1; m_want = 1'b1; m_paddr = m_pc; m_pc = m_pc + 32'd4;
        mem_busy = 1'b1; mem_cnt = lat; mem_addr = m_paddr;
      end
    end
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic st);
    for (int i = 0; i < n; i++) cycle(st, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
    lat = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst ValidF",   {31'b0, ValidF}, 32'd0);
    chk("rst InstrF",   InstrF, NOP);
    chk("rst PCF",      PCF, 32'h0);
    chk("rst PCPlus4F", PCPlus4F, 32'h4);
    chk("rst imem_req", {31'b0, imem.imem_req}, 32'd0);
    reset = 1'b1;

    // Latency 1 streaming: 0x0 then 0x4 on alternate cycles.
    idle_cycles(2, 1'b0);
    chk("s1 PCF0",   PCF, 32'h0);
    chk("s1 Instr0", InstrF, 32'hA5A5_0000);
    chk("s1 P4_0",   PCPlus4F, 32'h4);
    chk("s1 Valid0", {31'b0, ValidF}, 32'd1);
    idle_cycles(1, 1'b0);
    chk("s1 consumed", {31'b0, ValidF}, 32'd0);
    idle_cycles(1, 1'b0);
    chk("s1 PCF4",   PCF, 32'h4);
    chk("s1 Instr4", InstrF, 32'hA5A5_0004);

    // Stall four cycles with a valid slot, then release at latency 3.
    lat = 3;
    idle_cycles(4, 1'b1);
    chk("stall PCF", PCF, 32'h4);
    chk("stall Valid", {31'b0, ValidF}, 32'd1);
    chk("stall addr", imem.imem_addr, 32'h8);
    idle_cycles(1, 1'b0);

    // Redirect to 0x100 while waiting for 0x8; the 0x8 response is dropped.
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    idle_cycles(2, 1'b0);
    chk("drop Valid", {31'b0, ValidF}, 32'd0);
    chk("drop addr",  imem.imem_addr, 32'h100);
    lat = 1;
    idle_cycles(2, 1'b0);
    chk("redir PCF",   PCF, 32'h100);
    chk("redir Instr", InstrF, 32'hA5A5_0100);

    // Redirect coinciding with rvalid, unaligned target.
    idle_cycles(1, 1'b0);
    cycle(1'b0, 1'b1, 32'h203, 1'b0);
    chk("rv+redir Valid", {31'b0, ValidF}, 32'd0);
    chk("rv+redir addr",  imem.imem_addr, 32'h200);
    idle_cycles(2, 1'b0);
    chk("rv+redir PCF", PCF, 32'h200);

    // Redirect while stalled with a valid slot flushes anyway; empty slot may refill under stall.
    cycle(1'b1, 1'b1, 32'h300, 1'b0);
    chk("stall flush Valid", {31'b0, ValidF}, 32'd0);
    chk("stall flush Instr", InstrF, NOP);
    idle_cycles(2, 1'b1);
    chk("stall refill PCF", PCF, 32'h300);
    idle_cycles(1, 1'b0);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("wrap addr", imem.imem_addr, 32'hFFFF_FFFC);
    idle_cycles(2, 1'b0);
    chk("wrap PCF",  PCF, 32'hFFFF_FFFC);
    chk("wrap P4",   PCPlus4F, 32'h0);
    chk("wrap next", imem.imem_addr, 32'h0);

    // Async reset in the middle of a latency-3 wait.
    lat = 3;
    idle_cycles(1, 1'b0);
    @(negedge clk);
    imem.imem_rvalid = 1'b0; StallF = 1'b0; PCSrcE = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst PCF",   PCF, 32'h0);
    chk("arst P4",    PCPlus4F, 32'h4);
    chk("arst Instr", InstrF, NOP);
    chk("arst addr",  imem.imem_addr, 32'h0);
    chk("arst req",   {31'b0, imem.imem_req}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        st, rdr, spur;
      logic [31:0] tg;
      lat  = int'($urandom_range(1, 4));
      st   = ($urandom_range(0, 99) < 30);
      rdr  = ($urandom_range(0, 99) < 8);
      spur = ($urandom_range(0, 99) < 5);
      tg   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      cycle(st, rdr, tg, spur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
